// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: FloPoCo exception codes, IEEE constants and the
// FloPoCo-to-IEEE double conversion used by the y-vector write path.
package spmv_pkg;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

    typedef enum logic [1:0] {
        YW_IDLE   = 2'b00,
        YW_RUN    = 2'b01,
        YW_FINISH = 2'b10
    } yw_state_t;

    localparam logic [63:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;

    // Zero and infinity keep only the sign; every NaN collapses to the quiet NaN.
    function automatic logic [63:0] flopoco_to_ieee(input logic [65:0] v);
        logic [63:0] r;
        case (v[65:64])
            EXC_ZERO:   r = {v[63], 63'b0};
            EXC_NORMAL: r = v[63:0];
            EXC_INF:    r = {v[63], 11'h7FF, 52'b0};
            default:    r = IEEE_QNAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/std_fifo.sv
// Show-ahead synchronous FIFO. A write while full is accepted only when a read
// frees a slot in the same cycle, so a full FIFO can stream at full rate.
module std_fifo #(
    parameter int WIDTH             = 66,
    parameter int DEPTH             = 32,
    parameter int ALMOST_FULL_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(ALMOST_FULL_COUNT));
    assign rd_data     = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd) count_d = count_q + CW'(1);
        else if (do_rd && !do_wr) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/y_vector_writer.sv
// Drains intermediator y results through a FIFO, converts FloPoCo to IEEE
// double and issues sequential 64-bit write requests to the memory controller.
module y_vector_writer
    import spmv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 48,
    parameter int FIFO_DEPTH  = 32,
    parameter int ALMOST_FULL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           row_count,
    input  logic                  push_to_y,
    input  logic [65:0]           v_to_y,
    output logic                  stall_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [63:0]           mem_data,
    input  logic                  mem_stall,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            dbg_state
);
    // FIFO_DEPTH - ALMOST_FULL must cover the intermediator's in-flight results.
    yw_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           remaining_q, remaining_d;
    logic                  err_q, err_d;
    logic                  stall_q, stall_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [63:0]           mem_data_q, mem_data_d;

    logic        fifo_full, fifo_empty, fifo_almost_full;
    logic [65:0] fifo_rdata;
    logic        pop, push_ok;

    assign pop     = (state_q == YW_RUN) && !fifo_empty && !mem_stall && (remaining_q != 32'd0);
    assign push_ok = push_to_y && (state_q == YW_RUN);

    std_fifo #(
        .WIDTH            (66),
        .DEPTH            (FIFO_DEPTH),
        .ALMOST_FULL_COUNT(ALMOST_FULL)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (push_ok),
        .wr_data    (v_to_y),
        .rd_en      (pop),
        .rd_data    (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .almost_full(fifo_almost_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= YW_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            YW_IDLE: begin
                if (start) state_d = (row_count == 32'd0) ? YW_FINISH : YW_RUN;
            end
            YW_RUN: begin
                if (remaining_q == 32'd0) state_d = YW_FINISH;
            end
            YW_FINISH: state_d = YW_IDLE;
            default:   state_d = YW_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != YW_IDLE);
        done      = (state_q == YW_FINISH);
        dbg_state = state_q;
    end

    // Counters, error flag and the registered request stage
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        if ((state_q == YW_IDLE) && start) begin
            addr_d      = base_addr;
            remaining_d = row_count;
            err_d       = 1'b0;
        end
        if (pop) begin
            addr_d      = addr_q + ADDR_WIDTH'(8);
            remaining_d = remaining_q - 32'd1;
        end
        // A full FIFO still takes a push when a pop frees a slot the same cycle.
        if (push_to_y && (state_q != YW_RUN)) err_d = 1'b1;
        if (push_ok && fifo_full && !pop)     err_d = 1'b1;
        if (start && (state_q != YW_IDLE))    err_d = 1'b1;

        stall_d    = fifo_almost_full;
        mem_req_d  = pop;
        mem_addr_d = pop ? addr_q : mem_addr_q;
        mem_data_d = pop ? flopoco_to_ieee(fifo_rdata) : mem_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign err       = err_q;
    assign stall_out = stall_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;

endmodule
